// File: rtl/bmp180_disp_pkg.sv
// Shared types and constants for the BMP180 hex display: FSM states,
// active-low 7-segment codes {g,f,e,d,c,b,a} and default sizes.
package bmp180_disp_pkg;

  localparam int DEF_N_BITS = 20;
  localparam int DEF_N_DIG  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Indexed by decimal digit value; entry 9 is the leftmost element.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/bmp180_hex_display_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, N_BITS steps
// after a start pulse. done is high during the cycle of the final shift.
module bin2bcd_seq
  import bmp180_disp_pkg::*;
#(
  parameter int N_BITS = DEF_N_BITS,
  parameter int N_DIG  = DEF_N_DIG
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [N_BITS-1:0]    bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_DIG-1:0]   bcd
);

  localparam int CW = $clog2(N_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_BITS - 1);

  logic [N_BITS-1:0]        mag_q, mag_d;
  logic [4*N_DIG-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     run_q, run_d;
  logic [4*N_DIG+N_BITS-1:0] sh;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < N_DIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    sh    = {bcd_adj, mag_q} << 1;
    mag_d = mag_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      mag_d = bin;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = sh[4*N_DIG+N_BITS-1:N_BITS];
      mag_d = sh[N_BITS-1:0];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) run_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      mag_q <= mag_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign busy = run_q;
  assign done = run_q && (cnt_q == CNT_LAST);
  assign bcd  = bcd_q;

endmodule

// File: rtl/bmp180_hex_display.sv
// Captures a compensated BMP180 reading on I_UPD, converts its magnitude to
// BCD and drives six active-low 7-segment digits with sign and zero blanking.
module bmp180_hex_display
  import bmp180_disp_pkg::*;
#(
  parameter int N_BITS = DEF_N_BITS,
  parameter int N_DIG  = DEF_N_DIG
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] I_T_VALUE,
  input  logic [18:0] I_P_VALUE,
  input  logic        I_SEL,
  input  logic        I_UPD,
  output logic        O_BUSY,
  output logic [6:0]  O_HEX0,
  output logic [6:0]  O_HEX1,
  output logic [6:0]  O_HEX2,
  output logic [6:0]  O_HEX3,
  output logic [6:0]  O_HEX4,
  output logic [6:0]  O_HEX5
);

  disp_state_e              state_q;
  logic                     pending_q, neg_q, sel_q;
  logic [N_DIG-1:0][6:0]    hex_q, seg_d;
  logic [N_BITS-1:0]        val_d, mag_d;
  logic                     neg_d, start_d, seen;
  logic [3:0]               dig;
  logic                     cvt_busy, cvt_done;
  logic [4*N_DIG-1:0]       bcd;

  always_comb begin
    val_d = I_SEL ? {{(N_BITS-19){I_P_VALUE[18]}}, I_P_VALUE}
                  : {{(N_BITS-16){I_T_VALUE[15]}}, I_T_VALUE};
    neg_d = val_d[N_BITS-1];
    mag_d = neg_d ? (~val_d + 1'b1) : val_d;
    // A strobe landing in DONE restarts right away, same as a queued one.
    start_d = ((state_q == IDLE) && I_UPD) ||
              ((state_q == DONE) && (pending_q || I_UPD));
  end

  bin2bcd_seq #(.N_BITS(N_BITS), .N_DIG(N_DIG)) u_bcd (
    .CLK   (CLK),
    .RST   (RST),
    .start (start_d),
    .bin   (mag_d),
    .busy  (cvt_busy),
    .done  (cvt_done),
    .bcd   (bcd)
  );

  always_comb begin
    seen  = 1'b0;
    dig   = '0;
    seg_d = '0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      dig  = bcd[4*i +: 4];
      seen = seen || (dig != 4'd0) || (i == 0);
      seg_d[i] = seen ? seg_of(dig) : SEG_BLANK;
    end
    // Negative pressure is not physical: flag the whole display.
    if (neg_q && sel_q)       seg_d = {N_DIG{SEG_MINUS}};
    else if (neg_q && !sel_q) seg_d[N_DIG-1] = SEG_MINUS;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      neg_q     <= 1'b0;
      sel_q     <= 1'b0;
      hex_q     <= {N_DIG{SEG_BLANK}};
    end else begin
      if (start_d) begin
        sel_q <= I_SEL;
        neg_q <= neg_d;
      end
      case (state_q)
        IDLE: if (I_UPD) state_q <= CONV;
        CONV: begin
          if (I_UPD) pending_q <= 1'b1;
          if (cvt_done) state_q <= DONE;
        end
        DONE: begin
          hex_q     <= seg_d;
          pending_q <= 1'b0;
          state_q   <= start_d ? CONV : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign O_BUSY = (state_q != IDLE) || cvt_busy;
  assign O_HEX0 = hex_q[0];
  assign O_HEX1 = hex_q[1];
  assign O_HEX2 = hex_q[2];
  assign O_HEX3 = hex_q[3];
  assign O_HEX4 = hex_q[4];
  assign O_HEX5 = hex_q[5];

endmodule
